intersection_sequencer: RTL and testbench
=========================================

# intersection_sequencer

Central phase controller for the four-arm intersection. It drives the shared `stare_semafor` phase code, the slow tick strobe `clk_div` and the blink square wave `clk_div_int` into the four direction light blocks (NORD, SUD, EST, VEST). It advances phases on each direction's `ready_*` completion signal and inserts an all-red clearance between phases. It falls back to yellow-blink mode on night request or on a watchdog timeout.

## Interface
- `DIV`, default 50_000_000: clk cycles per slow tick; must be ≥ 2.
- `CLEAR_TICKS`, default 2: slow ticks spent in all-red clearance; must be ≥ 1.
- `BLINK_TICKS`, default 1: slow ticks per half-period of `clk_div_int`; must be ≥ 1.
- `TIMEOUT_TICKS`, default 40: maximum slow ticks in one green phase before a fault is declared.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `night_mode` in 1: level request for yellow-blink operation; synchronous to `clk`.
- `ready_N`, `ready_S`, `ready_E`, `ready_V` in 1 each: phase-complete signals from the direction blocks. Each may be a pulse or a level that stays high.
- `stare_semafor` out 3: phase code. 000 = SUD green, 001 = NORD, 010 = EST, 011 = VEST, 100 = all-red, 111 = blink.
- `clk_div` out 1: active-low one-cycle tick strobe.
- `clk_div_int` out 1: blink square wave.
- `fault` out 1: sticky watchdog flag.

## Operation
- Tick generator:
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `clk_div` = 0 for exactly the cycle where `div_cnt == DIV-1`, 1 otherwise.
  - A "tick" in this document means one such cycle.
- Blink generator: `clk_div_int` toggles after every BLINK_TICKS ticks. It runs free in all states.
- States: CLEAR (100), GREEN_S (000), GREEN_N (001), GREEN_E (010), GREEN_V (011), BLINK (111).
- Phase rotation: S → N → E → V → S. Every transition between two green states passes through CLEAR.
  - Register `next_dir` (2 bits) holds the green state to enter when CLEAR ends.
  - `next_dir` advances by one (mod 4) on each exit from a green state.
- CLEAR: after CLEAR_TICKS ticks, move to the green state selected by `next_dir`.
- GREEN_x:
  - Only the matching `ready_x` is watched; the other three are ignored.
  - Its rising edge (registered previous value 0, current value 1) ends the phase and moves to CLEAR.
  - On entry, the previous-value register is loaded with the current `ready_x`. A level still high from before therefore does not count as an edge.
  - A per-phase tick counter starts at 0 on entry. When it reaches TIMEOUT_TICKS with no edge, go to BLINK and set `fault`=1.
- `night_mode`=1 in any state except BLINK: go to BLINK on the next clock. This has priority over a simultaneous ready edge or clearance end.
- BLINK:
  - If `fault`=0 and `night_mode`=0, go to CLEAR with `next_dir`=S (00).
  - If `fault`=1, stay in BLINK until reset.
- Reset mid-phase: all state is abandoned immediately and outputs return to reset values.

## Timing
- Reset values:
  - `stare_semafor`=100 (CLEAR), `next_dir`=00, `fault`=0.
  - `clk_div`=1, `clk_div_int`=0, `div_cnt`=0, per-phase tick counter=0.
- All outputs are registered.
- `stare_semafor` changes exactly one clock after the qualifying event (ready edge, final clearance tick, or night sample).
- First strobe after reset: `clk_div` low during cycle DIV-1, counted from 0 at reset release. Then one strobe every DIV cycles.
- Tick counters advance only on strobe cycles.
  - CLEAR exits on the clock after its CLEAR_TICKS-th tick.
  - Tick counting restarts at 0 on every state entry; `div_cnt` does not reset on state change.
- Ready edge and timeout in the same cycle: the ready edge wins (CLEAR, no fault).

## Test plan
Test parameters: DIV=4, CLEAR_TICKS=2, BLINK_TICKS=1, TIMEOUT_TICKS=40.
1. Release reset and hold all `ready_*`=0. Required: `stare_semafor`=100; `clk_div` low at cycles 3, 7, 11…; `stare_semafor`=000 at cycle 8; `clk_div_int` toggles on the cycle after each strobe.
2. In GREEN_S, pulse `ready_S` for 1 cycle. Required: 100 on the next clock, then 001 after 2 ticks. Then pulse N, E, V in turn. Required sequence: 010, 011, 000, each separated by 100.
3. Enter GREEN_N with `ready_N` already held at 1. Required: no advance. Drop `ready_N` and raise it again. Required: advance to 100.
4. In GREEN_E, assert `ready_S` and `ready_V` only. Required: stays at 010. After 40 ticks: 111 and `fault`=1. Toggling `night_mode` does not exit 111; only reset clears it.
5. Assert `night_mode`=1 mid-GREEN_V. Required: 111 on the next clock, `clk_div_int` keeps toggling. Deassert. Required: 100 for 2 ticks, then 000.
6. Pulse `rst` low mid-CLEAR, asynchronously between clock edges. Required: outputs at reset values immediately; the sequence restarts as in test 1.

Source files
------------

// File: rtl/intersection_sequencer.sv
// Central phase controller for a four-arm intersection.
// Generates the slow tick strobe and blink wave, sequences green phases
// S -> N -> E -> V with an all-red clearance between them, and falls back
// to yellow blink on night request or on a green-phase watchdog timeout.
module intersection_sequencer #(
  parameter int DIV           = 50_000_000,
  parameter int CLEAR_TICKS   = 2,
  parameter int BLINK_TICKS   = 1,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       night_mode,
  input  logic       ready_N,
  input  logic       ready_S,
  input  logic       ready_E,
  input  logic       ready_V,
  output logic [2:0] stare_semafor,
  output logic       clk_div,
  output logic       clk_div_int,
  output logic       fault
);

  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PMAX = (CLEAR_TICKS > TIMEOUT_TICKS) ? CLEAR_TICKS : TIMEOUT_TICKS;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  // State encodings double as the phase code driven to the light blocks.
  typedef enum logic [2:0] {
    GREEN_S = 3'b000,
    GREEN_N = 3'b001,
    GREEN_E = 3'b010,
    GREEN_V = 3'b011,
    CLEAR   = 3'b100,
    BLINK   = 3'b111
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      next_dir, next_dir_nxt;
  logic            fault_nxt;
  logic [DW-1:0]   div_cnt, div_nxt;
  logic [BW-1:0]   blink_cnt;
  logic [PW-1:0]   phase_cnt;
  logic [3:0]      rdy_now, rdy_prev;
  logic [1:0]      cur_dir;
  logic            tick, rdy_edge, clear_done, timeout;

  assign tick    = (div_cnt == DW'(DIV - 1));
  assign div_nxt = tick ? '0 : div_cnt + 1'b1;

  // Indexed by direction code: S=0, N=1, E=2, V=3.
  assign rdy_now    = {ready_V, ready_E, ready_N, ready_S};
  assign cur_dir    = state[1:0];
  assign rdy_edge   = rdy_now[cur_dir] & ~rdy_prev[cur_dir];
  assign clear_done = tick && (phase_cnt == PW'(CLEAR_TICKS - 1));
  assign timeout    = tick && (phase_cnt == PW'(TIMEOUT_TICKS - 1));

  assign stare_semafor = state;

  // Free-running divider; the strobe is registered one cycle ahead so it
  // is low exactly while div_cnt sits at DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      clk_div <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      clk_div <= (div_nxt != DW'(DIV - 1));
    end
  end

  // Blink square wave, toggling after every BLINK_TICKS ticks in any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      clk_div_int <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt   <= '0;
        clk_div_int <= ~clk_div_int;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Previous ready levels; sampling every cycle means a level already high
  // when a green phase is entered never looks like a fresh edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy_prev <= '0;
    else      rdy_prev <= rdy_now;
  end

  // Per-phase tick counter, restarted on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         phase_cnt <= '0;
    else if (state_nxt != state)      phase_cnt <= '0;
    else if (tick && state != BLINK)  phase_cnt <= phase_cnt + 1'b1;
  end

  // FSM state, rotation pointer and sticky fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      next_dir <= 2'b00;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      next_dir <= next_dir_nxt;
      fault    <= fault_nxt;
    end
  end

  // Next-state logic: night request outranks everything outside BLINK,
  // and a ready edge outranks a simultaneous timeout.
  always_comb begin
    state_nxt    = state;
    next_dir_nxt = next_dir;
    fault_nxt    = fault;
    case (state)
      BLINK: begin
        if (!fault && !night_mode) begin
          state_nxt    = CLEAR;
          next_dir_nxt = 2'b00;
        end
      end
      CLEAR: begin
        if (night_mode)      state_nxt = BLINK;
        else if (clear_done) state_nxt = state_t'({1'b0, next_dir});
      end
      default: begin
        if (night_mode) begin
          state_nxt = BLINK;
        end else if (rdy_edge) begin
          state_nxt    = CLEAR;
          next_dir_nxt = next_dir + 2'd1;
        end else if (timeout) begin
          state_nxt    = BLINK;
          fault_nxt    = 1'b1;
          next_dir_nxt = next_dir + 2'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_intersection_sequencer.sv
// Randomized bench for intersection_sequencer against a cycle-count based
// reference model of the phase rules.
module tb_intersection_sequencer;

  localparam int DIV           = 4;
  localparam int CLEAR_TICKS   = 2;
  localparam int BLINK_TICKS   = 1;
  localparam int TIMEOUT_TICKS = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       night_mode = 1'b0;
  logic       ready_N = 1'b0, ready_S = 1'b0, ready_E = 1'b0, ready_V = 1'b0;
  logic [2:0] stare_semafor;
  logic       clk_div, clk_div_int, fault;

  int errs = 0;
  int chks = 0;

  intersection_sequencer #(
    .DIV(DIV), .CLEAR_TICKS(CLEAR_TICKS),
    .BLINK_TICKS(BLINK_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .night_mode(night_mode),
    .ready_N(ready_N), .ready_S(ready_S), .ready_E(ready_E), .ready_V(ready_V),
    .stare_semafor(stare_semafor), .clk_div(clk_div),
    .clk_div_int(clk_div_int), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: phase code as int (0..3 green dir, 4 clear, 7 blink),
  // ticks derived from the cycle count since reset release.
  int       m_cyc, m_code, m_next, m_fault, m_entry;
  bit [3:0] m_prev;

  task automatic model_reset();
    m_cyc = 0; m_code = 4; m_next = 0; m_fault = 0; m_entry = 0; m_prev = '0;
  endtask

  task automatic model_step();
    bit [3:0] cur;
    bit       tk;
    int       n, nc;
    cur = {ready_V, ready_E, ready_N, ready_S};
    tk  = (m_cyc % DIV) == DIV - 1;
    n   = (m_cyc + 1) / DIV - m_entry;
    nc  = m_code;
    if (m_code == 7) begin
      if (m_fault == 0 && !night_mode) begin nc = 4; m_next = 0; end
    end else if (night_mode) nc = 7;
    else if (m_code == 4) begin
      if (tk && n == CLEAR_TICKS) nc = m_next;
    end else if (cur[m_code] && !m_prev[m_code]) begin
      nc = 4; m_next = (m_code + 1) % 4;
    end else if (tk && n == TIMEOUT_TICKS) begin
      nc = 7; m_fault = 1;
    end
    if (nc != m_code) m_entry = (m_cyc + 1) / DIV;
    m_code = nc;
    m_prev = cur;
    m_cyc++;
  endtask

  function automatic logic [5:0] exp_vec();
    logic e_div, e_int;
    e_div = (m_cyc % DIV) != DIV - 1;
    e_int = ((m_cyc / DIV) / BLINK_TICKS) % 2 == 1;
    return {3'(m_code), e_div, e_int, (m_fault != 0)};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {stare_semafor, clk_div, clk_div_int, fault};
  endfunction

  task automatic set_ready(input bit [3:0] v);
    ready_S = v[0]; ready_N = v[1]; ready_E = v[2]; ready_V = v[3];
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; night_mode = 1'b0; set_ready(4'b0);
    repeat (3) @(negedge clk);
    chks++; if ({stare_semafor, clk_div, clk_div_int, fault} !== 6'b100_1_0_0) begin
      errs++; $display("FAIL reset_values: got %b want 100100", dut_vec());
    end
    rst = 1'b1; model_reset();
    chks++; if (dut_vec() !== exp_vec()) begin
      errs++; $display("FAIL reset_cycle0: got %b want %b", dut_vec(), exp_vec());
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      chks++; if (dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL startup c%0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (c == 3 || c == 7 || c == 11) begin
        chks++; if (clk_div !== 1'b0) begin
          errs++; $display("FAIL startup_strobe c%0d: got %b want 0", c, clk_div);
        end
      end
      if (c == 8) begin
        chks++; if (stare_semafor !== 3'b000) begin
          errs++; $display("FAIL startup_green c8: got %b want 000", stare_semafor);
        end
      end
    end
  endtask

  task automatic test_rotation();
    for (int k = 0; k < 4; k++) begin
      int w;
      bit [3:0] noise;
      w = $urandom_range(0, 6);
      for (int i = 0; i < w; i++) begin
        noise = 4'($urandom_range(0, 15));
        noise[k] = 1'b0;
        set_ready(noise);
        step();
        chks++; if (dut_vec() !== exp_vec()) begin
          errs++; $display("FAIL rotation_wait d%0d: got %b want %b", k, dut_vec(), exp_vec());
        end
      end
      set_ready(4'(1 << k));
      step();
      set_ready(4'b0);
      chks++; if (stare_semafor !== 3'b100) begin
        errs++; $display("FAIL rotation_clear d%0d: got %b want 100", k, stare_semafor);
      end
      for (int i = 0; i < 20 && m_code != (k + 1) % 4; i++) begin
        step();
        chks++; if (dut_vec() !== exp_vec()) begin
          errs++; $display("FAIL rotation_run d%0d: got %b want %b", k, dut_vec(), exp_vec());
        end
      end
      chks++; if (stare_semafor !== 3'((k + 1) % 4)) begin
        errs++; $display("FAIL rotation_next d%0d: got %b want %0d", k, stare_semafor, (k + 1) % 4);
      end
    end
  endtask

  task automatic test_held_level();
    set_ready(4'b0011);
    step();
    set_ready(4'b0010);
    for (int i = 0; i < 20 && m_code != 1; i++) step();
    for (int i = 0; i < 10; i++) begin
      step();
      chks++; if (dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL held_level: got %b want %b", dut_vec(), exp_vec());
      end
    end
    chks++; if (stare_semafor !== 3'b001) begin
      errs++; $display("FAIL held_no_advance: got %b want 001", stare_semafor);
    end
    set_ready(4'b0);
    repeat (2) step();
    set_ready(4'b0010);
    step();
    set_ready(4'b0);
    chks++; if (stare_semafor !== 3'b100) begin
      errs++; $display("FAIL held_reedge: got %b want 100", stare_semafor);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 20 && m_code != 2; i++) step();
    chks++; if (stare_semafor !== 3'b010) begin
      errs++; $display("FAIL timeout_enter_e: got %b want 010", stare_semafor);
    end
    for (int i = 0; i < TIMEOUT_TICKS * DIV + 8 && m_code != 7; i++) begin
      set_ready({1'($urandom_range(0, 1)), 2'b00, 1'($urandom_range(0, 1))});
      step();
      chks++; if (dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL timeout_run: got %b want %b", dut_vec(), exp_vec());
      end
    end
    set_ready(4'b0);
    chks++; if ({stare_semafor, fault} !== 4'b111_1) begin
      errs++; $display("FAIL timeout_fault: got %b/%b want 111/1", stare_semafor, fault);
    end
    for (int i = 0; i < 20; i++) begin
      night_mode = 1'($urandom_range(0, 1));
      step();
      chks++; if (dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL fault_sticky: got %b want %b", dut_vec(), exp_vec());
      end
    end
    night_mode = 1'b0;
    step();
    chks++; if (stare_semafor !== 3'b111) begin
      errs++; $display("FAIL fault_hold: got %b want 111", stare_semafor);
    end
    rst = 1'b0;
    #1;
    chks++; if ({stare_semafor, fault} !== 4'b100_0) begin
      errs++; $display("FAIL fault_reset: got %b/%b want 100/0", stare_semafor, fault);
    end
    @(negedge clk);
    rst = 1'b1; model_reset();
  endtask

  task automatic test_night();
    bit [3:0] rv;
    int w;
    rv = 4'b0;
    for (int i = 0; i < 200 && m_code != 3; i++) begin
      rv = (m_code < 4 && rv == 4'b0) ? 4'(1 << m_code) : 4'b0;
      set_ready(rv);
      step();
    end
    set_ready(4'b0);
    chks++; if (stare_semafor !== 3'b011) begin
      errs++; $display("FAIL night_enter_v: got %b want 011", stare_semafor);
    end
    w = $urandom_range(1, 10);
    repeat (w) step();
    night_mode = 1'b1;
    step();
    chks++; if (stare_semafor !== 3'b111) begin
      errs++; $display("FAIL night_blink: got %b want 111", stare_semafor);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      chks++; if (dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL night_run: got %b want %b", dut_vec(), exp_vec());
      end
    end
    night_mode = 1'b0;
    for (int i = 0; i < 30 && m_code != 0; i++) begin
      step();
      chks++; if (dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL night_exit: got %b want %b", dut_vec(), exp_vec());
      end
    end
    chks++; if (stare_semafor !== 3'b000) begin
      errs++; $display("FAIL night_to_s: got %b want 000", stare_semafor);
    end
  endtask

  task automatic test_async_reset();
    set_ready(4'b0001);
    step();
    set_ready(4'b0);
    step();
    chks++; if (stare_semafor !== 3'b100) begin
      errs++; $display("FAIL areset_midclear: got %b want 100", stare_semafor);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chks++; if ({stare_semafor, clk_div, clk_div_int, fault} !== 6'b100_1_0_0) begin
      errs++; $display("FAIL areset_immediate: got %b want 100100", dut_vec());
    end
    @(negedge clk);
    rst = 1'b1; model_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      chks++; if (dut_vec() !== exp_vec()) begin
        errs++; $display("FAIL areset_restart c%0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (c == 8) begin
        chks++; if (stare_semafor !== 3'b000) begin
          errs++; $display("FAIL areset_green c8: got %b want 000", stare_semafor);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_held_level();
    test_timeout();
    test_night();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
